// File: rtl/vm_pkg.sv
// Shared types and constants for the multi-product vending controller.
// Used by vm_coin_decoder and vending_machine_multi.
package vm_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vm_state_t;

    // Coin values in 10-cent units
    localparam logic [3:0] COIN_100 = 4'd10;
    localparam logic [3:0] COIN_50  = 4'd5;
    localparam logic [3:0] COIN_20  = 4'd2;
    localparam logic [3:0] COIN_10  = 4'd1;

    // Bit positions inside status_leds
    localparam int LED_IDLE       = 0;
    localparam int LED_COLLECTING = 1;
    localparam int LED_DISPENSING = 2;
    localparam int LED_SOLD_OUT   = 3;

endpackage : vm_pkg

// File: rtl/vm_coin_decoder.sv
// Coin acceptor decoder: turns the one-hot coin strobe into a credit value.
// A zero strobe means "no coin"; any strobe with more than one bit set is
// flagged as multi_hot so the controller can hand the coin back.
module vm_coin_decoder
    import vm_pkg::*;
(
    input  logic [3:0] coin,
    output logic       valid,
    output logic [3:0] value,
    output logic       multi_hot
);

    // Map each legal one-hot coin code to its value; everything else is invalid
    always_comb begin
        valid     = 1'b0;
        value     = 4'd0;
        multi_hot = 1'b0;
        case (coin)
            4'b0000: begin
                valid     = 1'b0;
                multi_hot = 1'b0;
            end
            4'b0001: begin
                valid = 1'b1;
                value = COIN_10;
            end
            4'b0010: begin
                valid = 1'b1;
                value = COIN_20;
            end
            4'b0100: begin
                valid = 1'b1;
                value = COIN_50;
            end
            4'b1000: begin
                valid = 1'b1;
                value = COIN_100;
            end
            default: begin
                multi_hot = 1'b1;
            end
        endcase
    end

endmodule : vm_coin_decoder

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: product selection, coin collection with
// rejection, cancel / idle-timeout refund, timed motor drive and change output.
// All outputs are registered and derived from the next-state values.
// Optional build macro VM_AUDIT_EN adds a saturating vend counter on
// sales_count; without it sales_count is tied to zero.
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int NUM_PRODUCTS    = 4,
    parameter int CREDIT_W        = 8,
    parameter int STOCK_W         = 4,
    parameter int INIT_STOCK      = 5,
    parameter int DISPENSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PRODUCTS-1:0]          product_select,
    input  logic [3:0]                       coin_insert,
    input  logic                             cancel,
    input  logic                             restock,
    input  logic [NUM_PRODUCTS*CREDIT_W-1:0] price_flat,
    output logic [7:0]                       lcd_display,
    output logic [NUM_PRODUCTS-1:0]          motor_control,
    output logic [3:0]                       status_leds,
    output logic                             coin_reject,
    output logic                             change_valid,
    output logic [CREDIT_W-1:0]              change_amount,
    output logic [15:0]                      sales_count
);

    localparam int IDX_W   = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DCNT_W  = $clog2(DISPENSE_CYCLES + 1);
    localparam int SUM_W   = CREDIT_W + 1;

    localparam logic [TIMER_W-1:0]      TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DCNT_W-1:0]       DCNT_LAST  = DCNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [SUM_W-1:0]        CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [STOCK_W-1:0]      STOCK_INIT = STOCK_W'(INIT_STOCK);
    localparam logic [NUM_PRODUCTS-1:0] MOTOR_ONE  = NUM_PRODUCTS'(1);

    // Fit a credit-width value onto the 8-bit display (zero-extend or truncate)
    function automatic logic [7:0] fit_credit(input logic [CREDIT_W-1:0] v);
        logic [CREDIT_W+7:0] ext;
        ext = {8'h00, v};
        return ext[7:0];
    endfunction

    // Display value for a slot index: shown to the user counting from 1
    function automatic logic [7:0] fit_slot(input logic [IDX_W-1:0] v);
        logic [IDX_W+7:0] ext;
        ext = {8'h00, v};
        return ext[7:0] + 8'd1;
    endfunction

    vm_state_t              state_r, state_n;
    logic [IDX_W-1:0]       idx_r, idx_n, sel_idx_s;
    logic                   sel_onehot_s;
    logic [CREDIT_W-1:0]    price_r, price_n;
    logic [CREDIT_W-1:0]    credit_r, credit_n, credit_new_s;
    logic [CREDIT_W-1:0]    change_r, change_n;
    logic [TIMER_W-1:0]     timer_r, timer_n;
    logic [DCNT_W-1:0]      dcnt_r, dcnt_n;
    logic [STOCK_W-1:0]     stock_r [NUM_PRODUCTS];
    logic [STOCK_W-1:0]     stock_n [NUM_PRODUCTS];
    logic                   sold_out_r, sold_out_n;

    logic                   coin_valid_s, coin_multi_s;
    logic [3:0]             coin_value_s;
    logic [SUM_W-1:0]       coin_sum_s;
    logic                   accept_s, reject_s, abort_s;

    logic [NUM_PRODUCTS-1:0] motor_n;
    logic [7:0]              lcd_n;
    logic [3:0]              leds_n;
    logic                    change_valid_n;
    logic [CREDIT_W-1:0]     change_amount_n;

    vm_coin_decoder u_coin_decoder (
        .coin      (coin_insert),
        .valid     (coin_valid_s),
        .value     (coin_value_s),
        .multi_hot (coin_multi_s)
    );

    // Decode the product keypad into a slot index and a one-hot qualifier
    always_comb begin
        sel_onehot_s = $onehot(product_select);
        sel_idx_s    = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (product_select[i]) begin
                sel_idx_s = IDX_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Classify the current coin: credited only in COLLECT without overflow
    always_comb begin
        coin_sum_s = {1'b0, credit_r} + SUM_W'(coin_value_s);
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        if (coin_multi_s) begin
            reject_s = 1'b1;
        end else if (coin_valid_s) begin
            if ((state_r == COLLECT) && (coin_sum_s <= CREDIT_MAX)) begin
                accept_s = 1'b1;
            end else begin
                reject_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Next-state logic for the controller FSM and its datapath registers
    always_comb begin
        state_n      = state_r;
        idx_n        = idx_r;
        price_n      = price_r;
        credit_n     = credit_r;
        change_n     = change_r;
        timer_n      = timer_r;
        dcnt_n       = dcnt_r;
        sold_out_n   = sold_out_r;
        stock_n      = stock_r;
        credit_new_s = credit_r;
        abort_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (restock) begin
                    for (int i = 0; i < NUM_PRODUCTS; i++) begin
                        stock_n[i] = STOCK_INIT;
                    end
                end else begin
                    stock_n = stock_r;
                end
                // Availability is judged on the stock held before this edge
                if (sel_onehot_s) begin
                    if (stock_r[sel_idx_s] != {STOCK_W{1'b0}}) begin
                        idx_n      = sel_idx_s;
                        price_n    = price_flat[sel_idx_s*CREDIT_W +: CREDIT_W];
                        credit_n   = {CREDIT_W{1'b0}};
                        timer_n    = {TIMER_W{1'b0}};
                        sold_out_n = 1'b0;
                        state_n    = COLLECT;
                    end else begin
                        sold_out_n = 1'b1;
                    end
                end else begin
                    sold_out_n = sold_out_r;
                end
            end

            COLLECT: begin
                if (accept_s) begin
                    credit_new_s = coin_sum_s[CREDIT_W-1:0];
                    timer_n      = {TIMER_W{1'b0}};
                end else begin
                    credit_new_s = credit_r;
                    timer_n      = timer_r + TIMER_W'(1);
                end
                credit_n = credit_new_s;
                // Idle expiry behaves exactly like a cancel request
                abort_s  = cancel || (!accept_s && (timer_r == TIMER_LAST));
                // Cancel wins over a purchase the same coin would complete
                if (abort_s) begin
                    change_n = credit_new_s;
                    state_n  = CHANGE;
                end else if (accept_s && (credit_new_s >= price_r)) begin
                    change_n = credit_new_s - price_r;
                    dcnt_n   = {DCNT_W{1'b0}};
                    state_n  = DISPENSE;
                    if (stock_r[idx_r] != {STOCK_W{1'b0}}) begin
                        stock_n[idx_r] = stock_r[idx_r] - STOCK_W'(1);
                    end else begin
                        stock_n[idx_r] = stock_r[idx_r];
                    end
                end else begin
                    state_n = COLLECT;
                end
            end

            DISPENSE: begin
                if (dcnt_r == DCNT_LAST) begin
                    state_n = CHANGE;
                end else begin
                    dcnt_n = dcnt_r + DCNT_W'(1);
                end
            end

            CHANGE: begin
                credit_n = {CREDIT_W{1'b0}};
                state_n  = IDLE;
            end

            default: begin
                credit_n = {CREDIT_W{1'b0}};
                state_n  = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        motor_n = {NUM_PRODUCTS{1'b0}};
        if (state_n == DISPENSE) begin
            motor_n = MOTOR_ONE << idx_n;
        end else begin
            motor_n = {NUM_PRODUCTS{1'b0}};
        end

        case (state_n)
            IDLE:     lcd_n = 8'd0;
            COLLECT:  lcd_n = fit_credit(credit_n);
            DISPENSE: lcd_n = fit_slot(idx_n);
            CHANGE:   lcd_n = fit_credit(change_n);
            default:  lcd_n = 8'd0;
        endcase

        leds_n                 = 4'b0000;
        leds_n[LED_SOLD_OUT]   = sold_out_n;
        leds_n[LED_DISPENSING] = (state_n == DISPENSE);
        leds_n[LED_COLLECTING] = (state_n == COLLECT);
        leds_n[LED_IDLE]       = (state_n == IDLE);

        change_valid_n = (state_n == CHANGE);
        if (change_valid_n) begin
            change_amount_n = change_n;
        end else begin
            change_amount_n = {CREDIT_W{1'b0}};
        end
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            idx_r         <= {IDX_W{1'b0}};
            price_r       <= {CREDIT_W{1'b0}};
            credit_r      <= {CREDIT_W{1'b0}};
            change_r      <= {CREDIT_W{1'b0}};
            timer_r       <= {TIMER_W{1'b0}};
            dcnt_r        <= {DCNT_W{1'b0}};
            sold_out_r    <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_r[i] <= STOCK_INIT;
            end
            motor_control <= {NUM_PRODUCTS{1'b0}};
            lcd_display   <= 8'd0;
            status_leds   <= 4'b0001;
            coin_reject   <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= {CREDIT_W{1'b0}};
        end else begin
            state_r       <= state_n;
            idx_r         <= idx_n;
            price_r       <= price_n;
            credit_r      <= credit_n;
            change_r      <= change_n;
            timer_r       <= timer_n;
            dcnt_r        <= dcnt_n;
            sold_out_r    <= sold_out_n;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_r[i] <= stock_n[i];
            end
            motor_control <= motor_n;
            lcd_display   <= lcd_n;
            status_leds   <= leds_n;
            coin_reject   <= reject_s;
            change_valid  <= change_valid_n;
            change_amount <= change_amount_n;
        end
    end

`ifdef VM_AUDIT_EN
    logic [15:0] sales_r;
    logic        audit_coin_r;

    // Count vends on DISPENSE entry (saturating) and strobe each credited coin
    always_ff @(posedge clk) begin
        if (reset) begin
            sales_r      <= 16'h0000;
            audit_coin_r <= 1'b0;
        end else begin
            if ((state_r == COLLECT) && (state_n == DISPENSE) && (sales_r != 16'hFFFF)) begin
                sales_r <= sales_r + 16'd1;
            end else begin
                sales_r <= sales_r;
            end
            audit_coin_r <= accept_s;
        end
    end

    assign sales_count = sales_r;
`else
    assign sales_count = 16'h0000;
`endif

endmodule : vending_machine_multi

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: directed scenarios plus a
// randomized vend/refund mix checked against a transaction-level model
// (per-slot stock, running credit, expected change and vend count).
module tb_vending_machine_multi;

    localparam int NP   = 4;
    localparam int CW   = 8;
    localparam int SW   = 4;
    localparam int INIT = 5;
    localparam int DC   = 4;
    localparam int TO   = 1000;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     product_select;
    logic [3:0]        coin_insert;
    logic              cancel;
    logic              restock;
    logic [NP*CW-1:0]  price_flat;
    logic [7:0]        lcd_display;
    logic [NP-1:0]     motor_control;
    logic [3:0]        status_leds;
    logic              coin_reject;
    logic              change_valid;
    logic [CW-1:0]     change_amount;
    logic [15:0]       sales_count;

    int errors = 0;
    int checks = 0;
    int stock_m [NP];
    int sales_m = 0;
    logic [3:0] coin_q [$];

    vending_machine_multi #(
        .NUM_PRODUCTS    (NP),
        .CREDIT_W        (CW),
        .STOCK_W         (SW),
        .INIT_STOCK      (INIT),
        .DISPENSE_CYCLES (DC),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .product_select (product_select),
        .coin_insert    (coin_insert),
        .cancel         (cancel),
        .restock        (restock),
        .price_flat     (price_flat),
        .lcd_display    (lcd_display),
        .motor_control  (motor_control),
        .status_leds    (status_leds),
        .coin_reject    (coin_reject),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .sales_count    (sales_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_val(input logic [3:0] c);
        case (c)
            4'b0000: return 0;
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 5;
            4'b1000: return 10;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) stock_m[i] = INIT;
        sales_m = 0;
    endtask

    // One full transaction on a slot, driven from coin_q; ends back in IDLE
    task automatic run_vend(input int slot, input int cancel_at, input bit scramble, input bit disp_coin);
        int credit;
        int price;
        int v;
        int outcome;
        bit rej;
        logic [NP-1:0] exp_motor;
        price = int'(price_flat[slot*CW +: CW]);
        product_select = NP'(1 << slot);
        tick();
        product_select = 4'b0000;
        if (scramble) price_flat[slot*CW +: CW] = CW'($urandom_range(1, 60));
        checks++;
        if (stock_m[slot] == 0) begin
            if (status_leds !== 4'b1001 || lcd_display !== 8'd0) begin
                errors++;
                $display("FAIL sold_out slot%0d: leds=%b lcd=%0d, expected leds=1001 lcd=0", slot, status_leds, lcd_display);
            end
            return;
        end
        if (status_leds !== 4'b0010 || lcd_display !== 8'd0) begin
            errors++;
            $display("FAIL select slot%0d: leds=%b lcd=%0d, expected leds=0010 lcd=0", slot, status_leds, lcd_display);
        end
        credit  = 0;
        outcome = 0;
        for (int k = 0; k < coin_q.size(); k++) begin
            v = coin_val(coin_q[k]);
            coin_insert = coin_q[k];
            cancel = (k == cancel_at);
            tick();
            coin_insert = 4'b0000;
            cancel = 1'b0;
            rej = (v < 0) || (v > 0 && credit + v > 255);
            checks++;
            if (coin_reject !== rej) begin
                errors++;
                $display("FAIL coin_reject coin%0d code=%b: got %b expected %b", k, coin_q[k], coin_reject, rej);
            end
            if (!rej && v > 0) credit += v;
            if (k == cancel_at) begin
                outcome = 1;
                break;
            end
            if (credit >= price) begin
                outcome = 2;
                break;
            end
            checks++;
            if (lcd_display !== 8'(credit) || status_leds !== 4'b0010) begin
                errors++;
                $display("FAIL collect coin%0d: lcd=%0d leds=%b, expected lcd=%0d leds=0010", k, lcd_display, status_leds, credit);
            end
        end
        if (outcome == 0) begin
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            outcome = 1;
        end
        if (outcome == 1) begin
            checks++;
            if (change_valid !== 1'b1 || change_amount !== 8'(credit) || motor_control !== 4'b0000 || lcd_display !== 8'(credit)) begin
                errors++;
                $display("FAIL refund slot%0d: valid=%b amount=%0d motor=%b lcd=%0d, expected valid=1 amount=%0d motor=0000",
                         slot, change_valid, change_amount, motor_control, lcd_display, credit);
            end
        end else begin
            exp_motor = NP'(1 << slot);
            for (int c = 0; c < DC; c++) begin
                if (c > 0) begin
                    if (disp_coin && c == 1) coin_insert = 4'b0001;
                    tick();
                    coin_insert = 4'b0000;
                end
                checks++;
                if (motor_control !== exp_motor || status_leds !== 4'b0100 || lcd_display !== 8'(slot + 1)) begin
                    errors++;
                    $display("FAIL dispense cycle%0d: motor=%b leds=%b lcd=%0d, expected motor=%b leds=0100 lcd=%0d",
                             c, motor_control, status_leds, lcd_display, exp_motor, slot + 1);
                end
                if (disp_coin && c == 1) begin
                    checks++;
                    if (coin_reject !== 1'b1) begin
                        errors++;
                        $display("FAIL dispense_coin_reject: got %b expected 1", coin_reject);
                    end
                end
            end
            tick();
            checks++;
            if (change_valid !== 1'b1 || change_amount !== 8'(credit - price) || motor_control !== 4'b0000) begin
                errors++;
                $display("FAIL change slot%0d: valid=%b amount=%0d motor=%b, expected valid=1 amount=%0d motor=0000",
                         slot, change_valid, change_amount, motor_control, credit - price);
            end
            stock_m[slot]--;
            sales_m++;
        end
        tick();
        checks++;
        if (status_leds !== 4'b0001 || change_valid !== 1'b0 || motor_control !== 4'b0000) begin
            errors++;
            $display("FAIL return_idle slot%0d: leds=%b valid=%b motor=%b, expected leds=0001 valid=0 motor=0000",
                     slot, status_leds, change_valid, motor_control);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        model_reset();
        checks++;
        if (motor_control !== 4'b0000 || coin_reject !== 1'b0 || change_valid !== 1'b0 ||
            change_amount !== 8'd0 || lcd_display !== 8'd0 || status_leds !== 4'b0001 || sales_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: motor=%b rej=%b cv=%b amt=%0d lcd=%0d leds=%b sales=%0d, expected all zero, leds=0001",
                     motor_control, coin_reject, change_valid, change_amount, lcd_display, status_leds, sales_count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (status_leds !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: leds=%b expected 0001", status_leds);
        end
    endtask

    task automatic test_single_coin();
        coin_q = {4'b1000};
        run_vend(0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_exact_multi();
        coin_q = {4'b0100, 4'b0010, 4'b0001};
        run_vend(1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_overpay();
        coin_q = {4'b1000};
        run_vend(1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_audit(input string tag);
        int exp;
`ifdef VM_AUDIT_EN
        exp = sales_m;
`else
        exp = 0;
`endif
        checks++;
        if (sales_count !== 16'(exp)) begin
            errors++;
            $display("FAIL audit_%s: sales_count=%0d expected %0d", tag, sales_count, exp);
        end
    endtask

    task automatic test_cancel_timeout();
        int n;
        bit seen;
        bit motor_seen;
        coin_q = {4'b0100};
        run_vend(2, 0, 1'b0, 1'b0);
        // Idle expiry: no cancel, wait for the automatic refund
        product_select = 4'b0100;
        tick();
        product_select = 4'b0000;
        coin_insert = 4'b0100;
        tick();
        coin_insert = 4'b0000;
        checks++;
        if (lcd_display !== 8'd5) begin
            errors++;
            $display("FAIL timeout_credit: lcd=%0d expected 5", lcd_display);
        end
        seen = 1'b0;
        motor_seen = 1'b0;
        n = 0;
        while (!seen && n < TO + 20) begin
            tick();
            n++;
            if (motor_control !== 4'b0000) motor_seen = 1'b1;
            if (change_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n < TO - 1 || n > TO + 1 || change_amount !== 8'd5 || motor_seen) begin
            errors++;
            $display("FAIL timeout_refund: seen=%b after %0d cycles amount=%0d motor_seen=%b, expected refund 5 after ~%0d cycles",
                     seen, n, change_amount, motor_seen, TO);
        end
        tick();
        checks++;
        if (status_leds !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_idle: leds=%b expected 0001", status_leds);
        end
    endtask

    task automatic test_sold_out();
        coin_q = {4'b1000};
        while (stock_m[0] > 0) run_vend(0, -1, 1'b0, 1'b0);
        run_vend(0, -1, 1'b0, 1'b0);
        tick();
        checks++;
        if (status_leds !== 4'b1001 || lcd_display !== 8'd0) begin
            errors++;
            $display("FAIL sold_out_hold: leds=%b lcd=%0d expected leds=1001 lcd=0", status_leds, lcd_display);
        end
        restock = 1'b1;
        tick();
        restock = 1'b0;
        for (int i = 0; i < NP; i++) stock_m[i] = INIT;
        run_vend(0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_coin_reject();
        coin_insert = 4'b0100;
        tick();
        coin_insert = 4'b0000;
        checks++;
        if (coin_reject !== 1'b1 || status_leds !== 4'b0001) begin
            errors++;
            $display("FAIL idle_coin: rej=%b leds=%b expected rej=1 leds=0001", coin_reject, status_leds);
        end
        product_select = 4'b0011;
        tick();
        product_select = 4'b0000;
        checks++;
        if (status_leds !== 4'b0001 || lcd_display !== 8'd0) begin
            errors++;
            $display("FAIL multi_select: leds=%b lcd=%0d expected leds=0001 lcd=0", status_leds, lcd_display);
        end
        coin_q = {4'b0110, 4'b0001, 4'b1000, 4'b1000, 4'b1000};
        run_vend(3, -1, 1'b0, 1'b1);
        // Credit ceiling: 250 + 10 overflows, 250 + 5 lands exactly on 255
        price_flat[3*CW +: CW] = 8'd255;
        coin_q.delete();
        for (int i = 0; i < 26; i++) coin_q.push_back(4'b1000);
        coin_q.push_back(4'b0100);
        run_vend(3, -1, 1'b0, 1'b0);
        price_flat[3*CW +: CW] = 8'd30;
    endtask

    task automatic test_reset_mid_vend();
        product_select = 4'b0010;
        tick();
        product_select = 4'b0000;
        coin_insert = 4'b1000;
        tick();
        coin_insert = 4'b0000;
        checks++;
        if (motor_control !== 4'b0010) begin
            errors++;
            $display("FAIL midvend_motor: motor=%b expected 0010", motor_control);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (motor_control !== 4'b0000 || status_leds !== 4'b0001 || change_valid !== 1'b0 || lcd_display !== 8'd0) begin
            errors++;
            $display("FAIL midvend_reset: motor=%b leds=%b cv=%b lcd=%0d expected 0000/0001/0/0",
                     motor_control, status_leds, change_valid, lcd_display);
        end
        reset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (change_valid !== 1'b0 || status_leds !== 4'b0001) begin
            errors++;
            $display("FAIL midvend_after: cv=%b leds=%b expected cv=0 leds=0001", change_valid, status_leds);
        end
    endtask

    task automatic test_random();
        int slot;
        int sel;
        logic [3:0] code;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                restock = 1'b1;
                tick();
                restock = 1'b0;
                for (int i = 0; i < NP; i++) stock_m[i] = INIT;
            end
            slot = $urandom_range(0, NP - 1);
            price_flat[slot*CW +: CW] = CW'($urandom_range(1, 60));
            coin_q.delete();
            for (int k = 0; k < 40; k++) begin
                sel = $urandom_range(0, 11);
                case (sel)
                    0, 1, 2: code = 4'b0001;
                    3, 4:    code = 4'b0010;
                    5, 6, 7: code = 4'b0100;
                    8, 9:    code = 4'b1000;
                    10:      code = 4'b0000;
                    default: code = 4'b1010;
                endcase
                coin_q.push_back(code);
            end
            run_vend(slot, $urandom_range(0, 45), 1'b1, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        product_select = 4'b0000;
        coin_insert = 4'b0000;
        cancel = 1'b0;
        restock = 1'b0;
        price_flat = {8'd30, 8'd20, 8'd8, 8'd10};
        model_reset();
        test_reset();
        test_single_coin();
        test_exact_multi();
        test_overpay();
        test_audit("after_three");
        test_cancel_timeout();
        test_sold_out();
        test_coin_reject();
        test_reset_mid_vend();
        test_audit("after_reset");
        test_random();
        test_audit("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vending_machine_multi
